cf_fft_1024_8_reorder: RTL and testbench
========================================

// Module: cf_fft_1024_8_reorder
// PURPOSE
//  Output reorder stage placed directly downstream of the 1024-point streaming FFT core.
//  - Accepts FFT results in bit-reversed index order, one complex sample per enabled cycle.
//  - Emits each frame in natural order, with a sync pulse on sample 0.
//  - Uses a ping-pong buffer of two banks, each 2^N_LOG2 complex words: one bank fills while the other drains.
// PARAMETERS
//  N_LOG2   10   log2 of frame length; bit reversal spans N_LOG2 bits
//  DW       16   width of each real/imag component
// PORTS
//  clock_c    in   1    single clock, rising edge
//  reset_i    in   1    synchronous, active-low reset
//  enable_i   in   1    global clock enable; all state advances only when 1
//  sync_i     in   1    marks first sample (index 0) of an input frame
//  data_0_i   in   DW   real part, bit-reversed order
//  data_1_i   in   DW   imag part, bit-reversed order
//  sync_o     out  1    one-enabled-cycle pulse with natural-order sample 0
//  data_0_o   out  DW   real part, natural order
//  data_1_o   out  DW   imag part, natural order
//  valid_o    out  1    1 while a complete frame is being emitted
// BEHAVIOUR
//  - Reset (reset_i=0 at a clock edge):
//    - State=IDLE; cnt=0; wbank=0.
//    - sync_o=0, valid_o=0, data_0_o=0, data_1_o=0.
//    - RAM contents are don't-care.
//  - enable_i=0: no state, counter, RAM write or output register changes; outputs hold.
//  - Write side, enabled cycle:
//    - Writes {data_0_i,data_1_i} to bank wbank, address bitrev(cnt).
//    - cnt counts 0..2^N_LOG2-1 and wraps.
//    - On cnt wrap, wbank toggles.
//    - sync_i=1 forces this sample to cnt=0.
//  - Read side shares cnt:
//    - Reads bank ~wbank at address cnt, natural order.
//    - RAM read is registered, then goes through an output register.
//    - Latency = 2 enabled cycles from read address to data_*_o.
//  - End-to-end latency: input sample 0 of frame F appears on data_*_o 2^N_LOG2+2 enabled cycles after its sync_i.
//  - FSM:
//    - IDLE -> FILL on sync_i.
//    - FILL -> STREAM on cnt wrap (first bank complete).
//    - STREAM -> STREAM on cnt wrap with sync_i at next sample or free-running.
//    - Any state -> FILL on mid-frame sync (sync_i=1 while cnt!=0). The partial bank is discarded, writing restarts at bitrev(0) in the same wbank, and valid_o drops 2 enabled cycles later.
//  - valid_o / sync_o track the read pipeline (2-cycle delayed):
//    - valid_o=1 for reads issued in STREAM.
//    - sync_o=1 for the read issued at cnt=0 in STREAM.
//  - No sync_i at frame boundary is legal: the counter free-runs and frames continue.
//  - sync_i coincident with cnt wrap (cnt=0 next) is a normal frame start, not an error.
//  - Outputs with valid_o=0 are driven to 0.
// CONFIGURATION
//  CF_REORDER_ERR_EN defined:
//    - Adds port err_o (out, 1): sticky; set on any mid-frame sync_i; cleared only by reset.
//  CF_REORDER_ERR_EN undefined:
//    - Port err_o absent.
//    - Mid-frame sync still recovers via FILL as above.
// TESTING
//  - Reset: drive reset_i=0 for 3 clocks with random inputs -> sync_o=0, valid_o=0, data=0; after release with no sync_i, outputs stay 0.
//  - Single frame (IDLE->FILL->STREAM): sync_i then 1024 samples with data_0_i=bitrev(k), data_1_i=~bitrev(k), followed by a second frame -> data_0_o=0,1,...,1023 in order, sync_o with 0 exactly 1026 enabled cycles after first sync_i, and valid_o=1 for 1024 cycles.
//  - Back-to-back frames: 4 consecutive frames -> valid_o continuously 1 from first output, sync_o every 1024 cycles, no gaps or repeats.
//  - Enable stall: enable_i toggled pseudo-randomly (50%) during the two-frame test -> identical output sequence; outputs hold while enable_i=0.
//  - Mid-frame sync: sync_i asserted at cnt=500 of frame 2 -> valid_o falls 2 enabled cycles later; next valid frame begins 1026 cycles after that sync; err_o=1 if CF_REORDER_ERR_EN.
//  - Reset mid-stream: reset_i=0 at cnt=300 in STREAM -> outputs 0 next cycle; a subsequent sync_i restarts FILL, and a full frame is output correctly.

Source files
------------

// File: rtl/cf_fft_1024_8_reorder_if.sv
// Stream bus of the FFT output reorder stage: bit-reversed input side, natural-order output side.
// Optional CF_REORDER_ERR_EN adds the sticky err_o flag to the bus.
interface cf_fft_1024_8_reorder_if #(
   parameter int unsigned DW = 16
) ();
   logic          enable_i;
   logic          sync_i;
   logic [DW-1:0] data_0_i;
   logic [DW-1:0] data_1_i;
   logic          sync_o;
   logic          valid_o;
   logic [DW-1:0] data_0_o;
   logic [DW-1:0] data_1_o;
`ifdef CF_REORDER_ERR_EN
   logic          err_o;

   modport master (
      output enable_i, sync_i, data_0_i, data_1_i,
      input  sync_o, valid_o, data_0_o, data_1_o, err_o
   );
   modport slave (
      input  enable_i, sync_i, data_0_i, data_1_i,
      output sync_o, valid_o, data_0_o, data_1_o, err_o
   );
`else
   modport master (
      output enable_i, sync_i, data_0_i, data_1_i,
      input  sync_o, valid_o, data_0_o, data_1_o
   );
   modport slave (
      input  enable_i, sync_i, data_0_i, data_1_i,
      output sync_o, valid_o, data_0_o, data_1_o
   );
`endif
endinterface

// File: rtl/cf_fft_1024_8_reorder.sv
// Reorders bit-reversed FFT output frames into natural order using a ping-pong buffer.
// One bank fills at bitrev(cnt) while the other drains at cnt; read data passes a RAM
// register and an output register (2 enabled cycles). Optional macro CF_REORDER_ERR_EN
// adds a sticky err_o flag raised on any mid-frame sync.
module cf_fft_1024_8_reorder #(
   parameter int unsigned N_LOG2 = 10,
   parameter int unsigned DW     = 16
) (
   input logic                   clock_c,
   input logic                   reset_i,
   cf_fft_1024_8_reorder_if.slave bus
);

   localparam int unsigned N = 1 << N_LOG2;

   typedef enum logic [1:0] {StIdle, StFill, StStream} state_e;

   state_e              state_q, state_d;
   logic [N_LOG2-1:0]   cnt_q, cnt_d, cnt_eff;
   logic                wbank_q, wbank_d;
   logic                mid_sync;
   logic                wrap;
   logic                rd_valid_d, rd_sync_d;
   logic                rd_valid_q, rd_sync_q;
   logic [2*DW-1:0]     rd_data_q;
   logic                out_valid_q, out_sync_q;
   logic [DW-1:0]       out_d0_q, out_d1_q;
   logic [2*DW-1:0]     mem [2][N];
`ifdef CF_REORDER_ERR_EN
   logic                err_q;
`endif

   function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
      logic [N_LOG2-1:0] r;
      for (int i = 0; i < int'(N_LOG2); i++) begin
         r[i] = v[int'(N_LOG2) - 1 - i];
      end
      return r;
   endfunction

   // Next-state: counter, bank select, FSM and read-pipeline tags for this cycle's read
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wbank_d    = wbank_q;
      rd_valid_d = 1'b0;
      rd_sync_d  = 1'b0;
      mid_sync   = bus.sync_i && (cnt_q != '0);
      // A sync always forces the current sample to index 0
      cnt_eff    = bus.sync_i ? '0 : cnt_q;
      wrap       = (cnt_eff == '1);
      unique case (state_q)
         StIdle: begin
            // Counter parks at 0 until the first frame starts
            if (bus.sync_i) begin
               state_d = StFill;
               cnt_d   = cnt_eff + 1'b1;
            end
         end
         StFill, StStream: begin
            cnt_d = cnt_eff + 1'b1;
            if (wrap) begin
               wbank_d = ~wbank_q;
               state_d = StStream;
            end
            // Partial frame is dropped; refill restarts in the same bank
            if (mid_sync) begin
               state_d = StFill;
            end
            if ((state_q == StStream) && !mid_sync) begin
               rd_valid_d = 1'b1;
               rd_sync_d  = (cnt_eff == '0);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Control state and output pipeline, synchronous active-low reset, gated by enable
   always_ff @(posedge clock_c) begin
      if (!reset_i) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         wbank_q     <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_sync_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_sync_q  <= 1'b0;
         out_d0_q    <= '0;
         out_d1_q    <= '0;
      end else if (bus.enable_i) begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wbank_q     <= wbank_d;
         rd_valid_q  <= rd_valid_d;
         rd_sync_q   <= rd_sync_d;
         out_valid_q <= rd_valid_q;
         out_sync_q  <= rd_sync_q;
         out_d0_q    <= rd_valid_q ? rd_data_q[2*DW-1:DW] : '0;
         out_d1_q    <= rd_valid_q ? rd_data_q[DW-1:0]    : '0;
      end
   end

   // Ping-pong RAM: write the filling bank, registered read of the draining bank
   always_ff @(posedge clock_c) begin
      if (bus.enable_i) begin
         mem[wbank_q][bitrev(cnt_eff)] <= {bus.data_0_i, bus.data_1_i};
         rd_data_q                     <= mem[~wbank_q][cnt_eff];
      end
   end

`ifdef CF_REORDER_ERR_EN
   // Sticky mid-frame sync flag, cleared only by reset
   always_ff @(posedge clock_c) begin
      if (!reset_i) begin
         err_q <= 1'b0;
      end else if (bus.enable_i && mid_sync) begin
         err_q <= 1'b1;
      end
   end

   assign bus.err_o = err_q;
`endif

   assign bus.sync_o   = out_sync_q;
   assign bus.valid_o  = out_valid_q;
   assign bus.data_0_o = out_d0_q;
   assign bus.data_1_o = out_d1_q;

endmodule

// File: tb/tb_cf_fft_1024_8_reorder.sv
// Randomized bench for cf_fft_1024_8_reorder against a frame-level reference model.
// Build with +define+CF_REORDER_ERR_EN to also check the sticky err_o flag.
module tb_cf_fft_1024_8_reorder;

   localparam int unsigned N_LOG2 = 10;
   localparam int unsigned DW     = 16;
   localparam int          N      = 1 << N_LOG2;

   logic clk;
   logic rst_n;

   cf_fft_1024_8_reorder_if #(.DW(DW)) bus ();

   cf_fft_1024_8_reorder #(
      .N_LOG2 (N_LOG2),
      .DW     (DW)
   ) dut (
      .clock_c (clk),
      .reset_i (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: a frame collected in natural order, then played back whole
   logic [2*DW-1:0] m_fill [N];
   logic [2*DW-1:0] m_play [N];
   int              m_pos;
   bit              m_active;
   bit              m_stream;
   logic [33:0]     m_prev;
   logic [33:0]     m_exp;

   // Observation trackers
   int ecyc = 0;
   int so_q[$];
   bit seen_valid;
   int fall_cyc;
   int gap_cnt;
   int fs_cyc;
   int mid_cyc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, ecyc);
      end
   endtask

   function automatic int tb_bitrev(input int v);
      int r = 0;
      for (int i = 0; i < int'(N_LOG2); i++) begin
         r = r * 2 + (v % 2);
         v = v / 2;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_pos    = 0;
      m_active = 0;
      m_stream = 0;
      m_prev   = '0;
      m_exp    = '0;
   endtask

   task automatic model_edge(input bit s, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      logic [33:0] cur;
      int          pos;
      cur = '0;
      if (s && m_active && m_pos != 0) m_stream = 0;
      if (s) m_active = 1;
      pos = s ? 0 : m_pos;
      if (m_active) begin
         if (m_stream) cur = {1'b1, (pos == 0), m_play[pos]};
         m_fill[tb_bitrev(pos)] = {d0, d1};
         if (pos == N - 1) begin
            m_play   = m_fill;
            m_stream = 1;
            m_pos    = 0;
         end else begin
            m_pos = pos + 1;
         end
      end
      m_exp  = m_prev;
      m_prev = cur;
   endtask

   task automatic clear_trk();
      so_q.delete();
      seen_valid = 0;
      fall_cyc   = -1;
      gap_cnt    = 0;
      fs_cyc     = -1;
      mid_cyc    = -1;
   endtask

   task automatic drive(input bit rn, input bit s, input bit en,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      rst_n        = rn;
      bus.enable_i = en;
      bus.sync_i   = s;
      bus.data_0_i = d0;
      bus.data_1_i = d1;
      @(posedge clk);
      #1;
      if (!rn) begin
         model_reset();
      end else if (en) begin
         model_edge(s, d0, d1);
         ecyc++;
         if (bus.sync_o) so_q.push_back(ecyc);
         if (bus.valid_o) begin
            seen_valid = 1;
         end else if (seen_valid) begin
            gap_cnt++;
            if (fall_cyc < 0) fall_cyc = ecyc;
         end
      end
      check("out", {30'd0, bus.valid_o, bus.sync_o, bus.data_0_o, bus.data_1_o}, {30'd0, m_exp});
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      end
   endtask

   // nfr frames with sync at sample 0; optional 50% stall and one mid-frame sync in frame 1
   task automatic frames(input int nfr, input bit stall, input int mid_at, input bit pat);
      int f = 0;
      int p = 0;
      bit mid_done = 0;
      bit en;
      bit s;
      logic [DW-1:0] d0, d1;
      while (f < nfr) begin
         en = stall ? 1'($urandom) : 1'b1;
         s  = (p == 0);
         if (en && mid_at >= 0 && f == 1 && p == mid_at && !mid_done) begin
            s        = 1;
            mid_done = 1;
            mid_cyc  = ecyc;
            p        = 0;
         end
         if (pat) begin
            d0 = 16'(tb_bitrev(p) + (f << N_LOG2));
            d1 = ~d0;
         end else begin
            d0 = 16'($urandom);
            d1 = 16'($urandom);
         end
         if (en && s && fs_cyc < 0) fs_cyc = ecyc;
         drive(1, s, en, d0, d1);
         if (en) begin
            p++;
            if (p == N) begin
               p = 0;
               f++;
            end
         end
      end
   endtask

   // n enabled samples with no sync (free-running counter)
   task automatic free(input int n, input bit stall);
      int k = 0;
      bit en;
      while (k < n) begin
         en = stall ? 1'($urandom) : 1'b1;
         drive(1, 0, en, 16'($urandom), 16'($urandom));
         if (en) k++;
      end
   endtask

   function automatic int so_at(input int idx);
      return (idx < so_q.size()) ? so_q[idx] : -1;
   endfunction

   initial begin
      model_reset();
      clear_trk();

      // Reset with random inputs, then idle without sync: outputs stay 0
      do_reset(3);
      free(20, 0);
      check("idle_no_valid", 64'(seen_valid), 64'd0);
`ifdef CF_REORDER_ERR_EN
      check("err_after_reset", 64'(bus.err_o), 64'd0);
`endif

      // Single frame followed by a second frame, spec data pattern
      clear_trk();
      frames(2, 0, -1, 1);
      free(8, 0);
      check("first_sync_lat", 64'(so_at(0) - fs_cyc), 64'(N + 2));
      check("sync_spacing", 64'(so_at(1) - so_at(0)), 64'(N));

      // Four back-to-back frames
      do_reset(1);
      clear_trk();
      frames(4, 0, -1, 0);
      free(4, 0);
      check("b2b_sync_count", 64'(so_q.size()), 64'd4);
      check("b2b_gaps", 64'(gap_cnt), 64'd0);
      for (int i = 1; i < 4; i++) begin
         check("b2b_spacing", 64'(so_at(i) - so_at(i - 1)), 64'(N));
      end

      // Enable stalls during the two-frame test
      do_reset(1);
      clear_trk();
      frames(2, 1, -1, 1);
      free(8, 1);
      check("stall_sync_lat", 64'(so_at(0) - fs_cyc), 64'(N + 2));
      check("stall_sync_spacing", 64'(so_at(1) - so_at(0)), 64'(N));

      // Mid-frame sync at cnt=500 of frame 2
      do_reset(1);
      clear_trk();
      frames(3, 0, 500, 0);
      free(1100, 0);
      check("mid_valid_fall", 64'(fall_cyc - mid_cyc), 64'd2);
      begin
         int nxt = -1;
         foreach (so_q[i]) if (nxt < 0 && so_q[i] > mid_cyc) nxt = so_q[i];
         check("mid_next_sync", 64'(nxt - mid_cyc), 64'(N + 2));
      end
`ifdef CF_REORDER_ERR_EN
      check("err_set", 64'(bus.err_o), 64'd1);
`endif

      // Reset at cnt=300 in STREAM, then restart
      do_reset(1);
      clear_trk();
      frames(1, 0, -1, 0);
      free(300, 0);
      check("pre_reset_valid", 64'(bus.valid_o), 64'd1);
      do_reset(1);
      check("rst_mid_valid", 64'(bus.valid_o), 64'd0);
      check("rst_mid_data", 64'({bus.data_0_o, bus.data_1_o}), 64'd0);
`ifdef CF_REORDER_ERR_EN
      check("err_cleared", 64'(bus.err_o), 64'd0);
`endif
      clear_trk();
      frames(2, 0, -1, 1);
      free(8, 0);
      check("restart_sync_lat", 64'(so_at(0) - fs_cyc), 64'(N + 2));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
